// File: rtl/decode_issue_stage_if.sv
// Bundle of fetch, register-file read, writeback and execute-side signals around the decode/issue stage.
// The slave view belongs to the stage itself; the master view belongs to its surroundings.
interface decode_issue_stage_if;
    logic        f_valid;
    logic        f_ready;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;

    logic [3:0]  rd_srcA;
    logic [3:0]  rd_srcB;
    logic [63:0] rd_valA;
    logic [63:0] rd_valB;

    logic        wb_en;
    logic [3:0]  wb_dstE;
    logic [63:0] wb_valE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valM;

    logic        e_valid;
    logic        e_ready;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] e_valC;
    logic [63:0] e_valA;
    logic [63:0] e_valB;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;

    logic        halted;
    logic        ins_err;

    modport slave (
        input  f_valid, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output f_ready,
        output rd_srcA, rd_srcB,
        input  rd_valA, rd_valB,
        input  wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        output e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
        input  e_ready,
        output halted, ins_err
    );

    modport master (
        output f_valid, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  f_ready,
        input  rd_srcA, rd_srcB,
        output rd_valA, rd_valB,
        output wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  e_valid, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE, e_dstM,
        output e_ready,
        input  halted, ins_err
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Y86 decode/issue stage: D register, register-file read ports, per-register write scoreboard, E register.
// Define DECODE_WB_FORWARD_EN to bypass same-cycle writeback values instead of waiting for the register file.
module decode_issue_stage #(
    parameter int unsigned SB_W    = 2,
    parameter logic [3:0]  RSP_IDX = 4'd4
) (
    input  logic                clk,
    input  logic                reset,
    decode_issue_stage_if.slave bus
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0]      REG_NONE = 4'hF;
    localparam logic [SB_W-1:0] SB_MAX   = {SB_W{1'b1}};

    logic        d_valid;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [3:0]  d_rA;
    logic [3:0]  d_rB;
    logic [63:0] d_valC;
    logic [63:0] d_valP;

    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] e_valC;
    logic [63:0] e_valA;
    logic [63:0] e_valB;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        halted;
    logic        ins_err;

    logic [SB_W-1:0] sb_cnt [16];
    logic [SB_W-1:0] sb_nxt [16];

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic        icode_bad, halting;
    logic        fwd_a, fwd_b, hazard;
    logic [63:0] op_a, op_b, dec_val_a;
    logic        issue, f_ready, accept;

    assign icode_bad = d_icode > I_POPQ;
    assign halting   = (d_icode == I_HALT) || icode_bad;

    // Register selection from the held D bundle; an empty D drives "no register" everywhere.
    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        if (d_valid) begin
            case (d_icode)
                I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = d_rA;
                I_RET, I_POPQ:                      src_a = RSP_IDX;
                default: ;
            endcase
            case (d_icode)
                I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = d_rB;
                I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP_IDX;
                default: ;
            endcase
            case (d_icode)
                I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = d_rB;
                I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP_IDX;
                default: ;
            endcase
            case (d_icode)
                I_MRMOVQ, I_POPQ:                   dst_m = d_rA;
                default: ;
            endcase
        end
    end

    // A destination that appears as both dstE and dstM needs room for two more writes.
    always_comb begin
        fwd_a  = 1'b0;
        fwd_b  = 1'b0;
`ifdef DECODE_WB_FORWARD_EN
        fwd_a = (src_a != REG_NONE) && (sb_cnt[src_a] == SB_W'(1)) && bus.wb_en &&
                ((bus.wb_dstE == src_a) || (bus.wb_dstM == src_a));
        fwd_b = (src_b != REG_NONE) && (sb_cnt[src_b] == SB_W'(1)) && bus.wb_en &&
                ((bus.wb_dstE == src_b) || (bus.wb_dstM == src_b));
`endif
        hazard = ((src_a != REG_NONE) && (sb_cnt[src_a] != '0) && !fwd_a) ||
                 ((src_b != REG_NONE) && (sb_cnt[src_b] != '0) && !fwd_b);
        if ((dst_e != REG_NONE) && (dst_e == dst_m)) begin
            if (sb_cnt[dst_e] >= SB_MAX - SB_W'(1)) hazard = 1'b1;
        end else begin
            if ((dst_e != REG_NONE) && (sb_cnt[dst_e] == SB_MAX)) hazard = 1'b1;
            if ((dst_m != REG_NONE) && (sb_cnt[dst_m] == SB_MAX)) hazard = 1'b1;
        end
    end

    always_comb begin
        op_a = bus.rd_valA;
        op_b = bus.rd_valB;
        if (fwd_a) op_a = (bus.wb_dstM == src_a) ? bus.wb_valM : bus.wb_valE;
        if (fwd_b) op_b = (bus.wb_dstM == src_b) ? bus.wb_valM : bus.wb_valE;
        dec_val_a = ((d_icode == I_JXX) || (d_icode == I_CALL)) ? d_valP : op_a;
    end

    assign issue   = d_valid && !hazard && (!e_valid || bus.e_ready);
    assign f_ready = !halted && (!d_valid || issue);
    assign accept  = bus.f_valid && f_ready;

    function automatic logic [SB_W-1:0] sb_step(input logic [SB_W-1:0] cnt,
                                                input logic [1:0]      inc,
                                                input logic [1:0]      dec);
        logic [SB_W+1:0] sum;
        logic [SB_W+1:0] sub;
        sum = {2'b00, cnt} + {{SB_W{1'b0}}, inc};
        sub = {{SB_W{1'b0}}, dec};
        sb_step = (sum > sub) ? SB_W'(sum - sub) : '0;
    endfunction

    // Entry 15 stands for "no register" and never counts.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            sb_nxt[i] = sb_step(sb_cnt[i],
                                {1'b0, issue && (dst_e == 4'(i))} + {1'b0, issue && (dst_m == 4'(i))},
                                {1'b0, bus.wb_en && (bus.wb_dstE == 4'(i))} +
                                {1'b0, bus.wb_en && (bus.wb_dstM == 4'(i))});
        end
        sb_nxt[15] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) sb_cnt <= '{default: '0};
        else       sb_cnt <= sb_nxt;
    end

    // A halting instruction leaving D also discards any beat accepted alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid <= 1'b0;
            d_icode <= '0;
            d_ifun  <= '0;
            d_rA    <= REG_NONE;
            d_rB    <= REG_NONE;
            d_valC  <= '0;
            d_valP  <= '0;
        end else if (issue && halting) begin
            d_valid <= 1'b0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_icode <= bus.f_icode;
            d_ifun  <= bus.f_ifun;
            d_rA    <= bus.f_rA;
            d_rB    <= bus.f_rB;
            d_valC  <= bus.f_valC;
            d_valP  <= bus.f_valP;
        end else if (issue) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid <= 1'b0;
            e_icode <= '0;
            e_ifun  <= '0;
            e_valC  <= '0;
            e_valA  <= '0;
            e_valB  <= '0;
            e_dstE  <= REG_NONE;
            e_dstM  <= REG_NONE;
            halted  <= 1'b0;
            ins_err <= 1'b0;
        end else if (issue) begin
            e_valid <= 1'b1;
            e_icode <= d_icode;
            e_ifun  <= d_ifun;
            e_valC  <= d_valC;
            e_valA  <= dec_val_a;
            e_valB  <= op_b;
            e_dstE  <= dst_e;
            e_dstM  <= dst_m;
            if (halting)   halted  <= 1'b1;
            if (icode_bad) ins_err <= 1'b1;
        end else if (bus.e_ready) begin
            e_valid <= 1'b0;
        end
    end

    assign bus.f_ready = f_ready;
    assign bus.rd_srcA = src_a;
    assign bus.rd_srcB = src_b;
    assign bus.e_valid = e_valid;
    assign bus.e_icode = e_icode;
    assign bus.e_ifun  = e_ifun;
    assign bus.e_valC  = e_valC;
    assign bus.e_valA  = e_valA;
    assign bus.e_valB  = e_valB;
    assign bus.e_dstE  = e_dstE;
    assign bus.e_dstM  = e_dstM;
    assign bus.halted  = halted;
    assign bus.ins_err = ins_err;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected E bundles are queued at fetch accept and
// popped as execute takes them; a small register-file model answers the read ports.
module tb_decode_issue_stage;

    localparam logic [3:0] NONE = 4'hF;
`ifdef DECODE_WB_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_issue_stage_if bus();

    decode_issue_stage #(.SB_W(2), .RSP_IDX(4'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] rf [16] = '{0: 64'hAA, 3: 64'h33, 4: 64'h44, default: 64'h0};

    // Register file sits downstream of writeback; the M port wins a same-register collision.
    always @(posedge clk) begin
        if (bus.wb_en) begin
            if (bus.wb_dstE != NONE) rf[bus.wb_dstE] <= bus.wb_valE;
            if (bus.wb_dstM != NONE) rf[bus.wb_dstM] <= bus.wb_valM;
        end
    end

    assign bus.rd_valA = rf[bus.rd_srcA];
    assign bus.rd_valB = rf[bus.rd_srcB];

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] ifun,
                                 input logic [3:0] rA, input logic [3:0] rB,
                                 input logic [63:0] valC, input logic [63:0] valP,
                                 input logic expect_issue,
                                 input logic [63:0] xA, input logic [63:0] xB,
                                 input logic [3:0] xE, input logic [3:0] xM);
        logic accepted;
        exp_t e;
        accepted    = 1'b0;
        bus.f_valid = 1'b1;
        bus.f_icode = icode;
        bus.f_ifun  = ifun;
        bus.f_rA    = rA;
        bus.f_rB    = rB;
        bus.f_valC  = valC;
        bus.f_valP  = valP;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (bus.f_ready === 1'b1) begin
                accepted = 1'b1;
                if (expect_issue) begin
                    e = '{icode, ifun, valC, xA, xB, xE, xM};
                    sb_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.f_valid = 1'b0;
        checkOutput("f_accept", 64'(accepted), 64'd1);
    endtask

    task automatic doWb(input logic [3:0] dE, input logic [63:0] vE, input logic [3:0] dM, input logic [63:0] vM);
        bus.wb_en   = 1'b1;
        bus.wb_dstE = dE;
        bus.wb_valE = vE;
        bus.wb_dstM = dM;
        bus.wb_valM = vM;
        @(posedge clk);
        #1;
        bus.wb_en   = 1'b0;
        bus.wb_dstE = NONE;
        bus.wb_dstM = NONE;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        bus.f_valid = 1'b0;
        bus.f_icode = '0;
        bus.f_ifun  = '0;
        bus.f_rA    = NONE;
        bus.f_rB    = NONE;
        bus.f_valC  = '0;
        bus.f_valP  = '0;
        bus.e_ready = 1'b1;
        bus.wb_en   = 1'b0;
        bus.wb_dstE = NONE;
        bus.wb_valE = '0;
        bus.wb_dstM = NONE;
        bus.wb_valM = '0;

        // Scoreboard consumer: every E transfer must match the oldest expectation.
        fork
            forever begin
                exp_t got;
                @(negedge clk);
                if (reset === 1'b0 && bus.e_valid === 1'b1 && bus.e_ready === 1'b1) begin
                    checkOutput("sb_pending", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        got = sb_q.pop_front();
                        checkOutput("e_icode", 64'(bus.e_icode), 64'(got.icode));
                        checkOutput("e_ifun",  64'(bus.e_ifun),  64'(got.ifun));
                        checkOutput("e_valC",  bus.e_valC,       got.valC);
                        checkOutput("e_valA",  bus.e_valA,       got.valA);
                        checkOutput("e_valB",  bus.e_valB,       got.valB);
                        checkOutput("e_dstE",  64'(bus.e_dstE),  64'(got.dstE));
                        checkOutput("e_dstM",  64'(bus.e_dstM),  64'(got.dstM));
                    end
                end
            end
        join_none

        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("rst_e_valid", 64'(bus.e_valid), 64'd0);
        checkOutput("rst_e_dstE",  64'(bus.e_dstE),  64'hF);
        checkOutput("rst_e_dstM",  64'(bus.e_dstM),  64'hF);
        checkOutput("rst_rd_srcA", 64'(bus.rd_srcA), 64'hF);
        checkOutput("rst_rd_srcB", 64'(bus.rd_srcB), 64'hF);
        checkOutput("rst_halted",  64'(bus.halted),  64'd0);
        checkOutput("rst_ins_err", 64'(bus.ins_err), 64'd0);
        checkOutput("rst_e_valC",  bus.e_valC,       64'd0);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_f_ready", 64'(bus.f_ready), 64'd1);
        nextCycle();

        $display("[TB] irmovq $5,%%rax");
        applyStimulus(4'h3, 4'h0, NONE, 4'h0, 64'd5, 64'h10A, 1'b1, 64'h0, 64'h0, 4'h0, NONE);
        @(negedge clk);
        checkOutput("t1_in_d", 64'(bus.e_valid), 64'd0);
        @(negedge clk);
        checkOutput("t1_latency", 64'(bus.e_valid), 64'd1);
        nextCycle();

        $display("[TB] addq %%rax,%%rbx waits on writeback of %%rax");
        applyStimulus(4'h6, 4'h0, 4'h0, 4'h3, 64'd0, 64'h10C, 1'b1, 64'd5, 64'h33, 4'h3, NONE);
        repeat (3) begin
            @(negedge clk);
            checkOutput("t2_hold",   64'(bus.e_valid), 64'd0);
            checkOutput("t2_fready", 64'(bus.f_ready), 64'd0);
            nextCycle();
        end
        doWb(4'h0, 64'd5, NONE, 64'd0);
        @(negedge clk);
        checkOutput("t2_wb_issue", 64'(bus.e_valid), 64'(FWD));
`ifndef DECODE_WB_FORWARD_EN
        nextCycle();
        @(negedge clk);
        checkOutput("t2_rf_issue", 64'(bus.e_valid), 64'd1);
`endif
        checkOutput("t2_cnt_rax", 64'(dut.sb_cnt[0]), 64'd0);
        checkOutput("t2_cnt_rbx", 64'(dut.sb_cnt[3]), 64'd1);
        nextCycle();

        $display("[TB] popq %%rsp then rrmovq %%rsp,%%rcx");
        applyStimulus(4'hB, 4'h0, 4'h4, NONE, 64'd0, 64'h10E, 1'b1, 64'h44, 64'h44, 4'h4, 4'h4);
        @(negedge clk);
        checkOutput("t3_srcA", 64'(bus.rd_srcA), 64'd4);
        checkOutput("t3_srcB", 64'(bus.rd_srcB), 64'd4);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_cnt2", 64'(dut.sb_cnt[4]), 64'd2);
        nextCycle();
        applyStimulus(4'h2, 4'h0, 4'h4, 4'h1, 64'd0, 64'h110, 1'b1, 64'h60, 64'h0, 4'h1, NONE);
        repeat (2) begin
            @(negedge clk);
            checkOutput("t3_hold", 64'(bus.e_valid), 64'd0);
            nextCycle();
        end
        doWb(4'h4, 64'h50, NONE, 64'd0);
        @(negedge clk);
        checkOutput("t3_wb1_hold", 64'(bus.e_valid), 64'd0);
        checkOutput("t3_cnt1", 64'(dut.sb_cnt[4]), 64'd1);
        nextCycle();
        doWb(4'h4, 64'h70, 4'h4, 64'h60);
        @(negedge clk);
        checkOutput("t3_wb2_issue", 64'(bus.e_valid), 64'(FWD));
        checkOutput("t3_cnt0", 64'(dut.sb_cnt[4]), 64'd0);
`ifndef DECODE_WB_FORWARD_EN
        nextCycle();
        @(negedge clk);
        checkOutput("t3_rf_issue", 64'(bus.e_valid), 64'd1);
`endif
        nextCycle();

        $display("[TB] back-pressure with two bundles queued");
        bus.e_ready = 1'b0;
        applyStimulus(4'h3, 4'h0, NONE, 4'h2, 64'd7, 64'h11A, 1'b1, 64'h0, 64'h0, 4'h2, NONE);
        applyStimulus(4'h3, 4'h0, NONE, 4'h6, 64'd9, 64'h124, 1'b1, 64'h0, 64'h0, 4'h6, NONE);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_fready", 64'(bus.f_ready), 64'd0);
            checkOutput("t4_e_valid", 64'(bus.e_valid), 64'd1);
            checkOutput("t4_e_hold", bus.e_valC, 64'd7);
            checkOutput("t4_d_hold", dut.d_valC, 64'd9);
            nextCycle();
        end
        bus.e_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_first", bus.e_valC, 64'd7);
        nextCycle();
        @(negedge clk);
        checkOutput("t4_second", bus.e_valC, 64'd9);
        nextCycle();

        $display("[TB] reset with live scoreboard and E bundle");
        bus.e_ready = 1'b0;
        applyStimulus(4'h3, 4'h0, NONE, 4'h8, 64'd1, 64'h12E, 1'b1, 64'h0, 64'h0, 4'h8, NONE);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_pre_valid", 64'(bus.e_valid), 64'd1);
        checkOutput("t6_pre_cnt", 64'(dut.sb_cnt[8]), 64'd1);
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        bus.e_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checkOutput("t6_e_valid", 64'(bus.e_valid), 64'd0);
        checkOutput("t6_e_dstE", 64'(bus.e_dstE), 64'hF);
        checkOutput("t6_cnt8", 64'(dut.sb_cnt[8]), 64'd0);
        checkOutput("t6_cnt2", 64'(dut.sb_cnt[2]), 64'd0);
        checkOutput("t6_cnt3", 64'(dut.sb_cnt[3]), 64'd0);
        nextCycle();

        $display("[TB] invalid icode 4'hD");
        applyStimulus(4'hD, 4'h3, 4'h1, 4'h2, 64'hDD, 64'h130, 1'b1, 64'h0, 64'h0, NONE, NONE);
        nextCycle();
        @(negedge clk);
        checkOutput("t5_ins_err", 64'(bus.ins_err), 64'd1);
        checkOutput("t5_halted", 64'(bus.halted), 64'd1);
        checkOutput("t5_cnt1", 64'(dut.sb_cnt[1]), 64'd0);
        checkOutput("t5_cnt2", 64'(dut.sb_cnt[2]), 64'd0);
        nextCycle();
        bus.f_valid = 1'b1;
        bus.f_icode = 4'h1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t5_fready", 64'(bus.f_ready), 64'd0);
            nextCycle();
        end
        bus.f_valid = 1'b0;
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_clr_halted", 64'(bus.halted), 64'd0);
        checkOutput("t5_clr_ins_err", 64'(bus.ins_err), 64'd0);
        checkOutput("t5_clr_fready", 64'(bus.f_ready), 64'd1);
        nextCycle();

        $display("[TB] halt drops the beat accepted behind it");
        applyStimulus(4'h0, 4'h0, NONE, NONE, 64'd0, 64'h131, 1'b1, 64'h0, 64'h0, NONE, NONE);
        applyStimulus(4'h1, 4'h0, NONE, NONE, 64'd0, 64'h132, 1'b0, 64'h0, 64'h0, NONE, NONE);
        @(negedge clk);
        checkOutput("t7_halted", 64'(bus.halted), 64'd1);
        checkOutput("t7_ins_err", 64'(bus.ins_err), 64'd0);
        checkOutput("t7_fready", 64'(bus.f_ready), 64'd0);
        checkOutput("t7_d_cleared", 64'(dut.d_valid), 64'd0);
        nextCycle();
        repeat (3) begin
            @(negedge clk);
            checkOutput("t7_quiet", 64'(bus.e_valid), 64'd0);
            nextCycle();
        end

        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
